// File: rtl/operand_bypass.sv
// operand_bypass: ID-to-EXE pipeline register with operand forwarding.
//
// Operand 1 and operand 2 each come from the register file or from a later
// pipeline stage (EXE/MEM result or SP). The stack pointer comes from the ID
// read or from the EXE/MEM SP values. Every output is a flop, so the block
// adds exactly one cycle of latency and has no input-to-output path.
// On each clock edge the first matching rule applies:
//   1. flush_i: load a bubble (all outputs zero).
//   2. stall_i: load a bubble (all outputs zero).
//   3. otherwise (advance): load the ID instruction and its resolved operands.
// A reserved select code that arrives on an advance cycle sets the sticky
// bad_code_o flag. Only reset clears it.
//
// Optional feature, enabled by defining the macro BEXKAT1_BYPASS_PERF_EN:
//   stall_cnt_o counts stall cycles and fwd_cnt_o counts forwarded
//   instructions. Both are 16-bit counters that saturate at 16'hFFFF.
//   When the macro is undefined, both counters are tied to zero.

module operand_bypass #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [2:0]       hazard1_i,
   input  logic [2:0]       hazard2_i,
   input  logic [1:0]       sp_hazard_i,
   input  logic [63:0]      id_ir_i,
   input  logic [WIDTH-1:0] id_data1_i,
   input  logic [WIDTH-1:0] id_data2_i,
   input  logic [WIDTH-1:0] id_sp_i,
   input  logic [WIDTH-1:0] exe_result_i,
   input  logic [WIDTH-1:0] exe_sp_i,
   input  logic [WIDTH-1:0] mem_result_i,
   input  logic [WIDTH-1:0] mem_sp_i,
   output logic [63:0]      exe_ir_o,
   output logic             exe_valid_o,
   output logic [WIDTH-1:0] exe_data1_o,
   output logic [WIDTH-1:0] exe_data2_o,
   output logic [WIDTH-1:0] exe_sp_o,
   output logic             bad_code_o,
   output logic [15:0]      stall_cnt_o,
   output logic [15:0]      fwd_cnt_o
);

   // What the pipeline register does on the coming edge.
   typedef enum logic [1:0] {
      MODE_FLUSH   = 2'd0,
      MODE_STALL   = 2'd1,
      MODE_ADVANCE = 2'd2
   } mode_e;

   localparam logic [63:0]      BUBBLE_IR = 64'h0;
   localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};

   // Operand select: pick the register-file value or a forwarded stage value.
   // Reserved codes fall back to the register-file value.
   function automatic logic [WIDTH-1:0] sel_operand(
      input logic [2:0]       code,
      input logic [WIDTH-1:0] rf_val,
      input logic [WIDTH-1:0] mem_res,
      input logic [WIDTH-1:0] exe_res,
      input logic [WIDTH-1:0] mem_sp,
      input logic [WIDTH-1:0] exe_sp
   );
      logic [WIDTH-1:0] val;
      case (code)
         3'd0:    val = rf_val;
         3'd1:    val = mem_res;
         3'd2:    val = exe_res;
         3'd3:    val = mem_sp;
         3'd4:    val = exe_sp;
         default: val = rf_val;
      endcase
      return val;
   endfunction

   // Stack-pointer select. Reserved code 3 falls back to the ID-stage SP.
   function automatic logic [WIDTH-1:0] sel_sp(
      input logic [1:0]       code,
      input logic [WIDTH-1:0] id_sp,
      input logic [WIDTH-1:0] exe_sp,
      input logic [WIDTH-1:0] mem_sp
   );
      logic [WIDTH-1:0] val;
      case (code)
         2'd0:    val = id_sp;
         2'd1:    val = exe_sp;
         2'd2:    val = mem_sp;
         default: val = id_sp;
      endcase
      return val;
   endfunction

   // Operand codes 5..7 are unassigned.
   function automatic logic op_code_reserved(input logic [2:0] code);
      return (code >= 3'd5);
   endfunction

   // SP code 3 is unassigned.
   function automatic logic sp_code_reserved(input logic [1:0] code);
      return (code == 2'd3);
   endfunction

   mode_e            mode_s;
   logic             reserved_s;
   logic             any_fwd_s;

   logic [63:0]      ir_d,    ir_q;
   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data1_d, data1_q;
   logic [WIDTH-1:0] data2_d, data2_q;
   logic [WIDTH-1:0] sp_d,    sp_q;
   logic             bad_d,   bad_q;

   // Decide the update mode (flush over stall over advance) and classify the select codes.
   always_comb begin
      mode_s     = MODE_ADVANCE;
      reserved_s = 1'b0;
      any_fwd_s  = 1'b0;
      if (flush_i) begin
         mode_s = MODE_FLUSH;
      end else if (stall_i) begin
         mode_s = MODE_STALL;
      end else begin
         mode_s = MODE_ADVANCE;
      end
      reserved_s = op_code_reserved(hazard1_i) | op_code_reserved(hazard2_i) |
                   sp_code_reserved(sp_hazard_i);
      any_fwd_s  = (hazard1_i != 3'd0) | (hazard2_i != 3'd0) | (sp_hazard_i != 2'd0);
   end

   // Next-state for the pipeline register: a bubble on flush/stall, resolved operands on advance.
   always_comb begin
      ir_d    = BUBBLE_IR;
      valid_d = 1'b0;
      data1_d = ZERO_W;
      data2_d = ZERO_W;
      sp_d    = ZERO_W;
      bad_d   = bad_q;
      case (mode_s)
         MODE_ADVANCE: begin
            ir_d    = id_ir_i;
            valid_d = (id_ir_i != BUBBLE_IR);
            data1_d = sel_operand(hazard1_i, id_data1_i, mem_result_i, exe_result_i,
                                  mem_sp_i, exe_sp_i);
            data2_d = sel_operand(hazard2_i, id_data2_i, mem_result_i, exe_result_i,
                                  mem_sp_i, exe_sp_i);
            sp_d    = sel_sp(sp_hazard_i, id_sp_i, exe_sp_i, mem_sp_i);
            if (reserved_s) begin
               bad_d = 1'b1;
            end else begin
               bad_d = bad_q;
            end
         end
         MODE_FLUSH, MODE_STALL: begin
            ir_d    = BUBBLE_IR;
            valid_d = 1'b0;
            data1_d = ZERO_W;
            data2_d = ZERO_W;
            sp_d    = ZERO_W;
            bad_d   = bad_q;
         end
         default: begin
            ir_d    = BUBBLE_IR;
            valid_d = 1'b0;
            data1_d = ZERO_W;
            data2_d = ZERO_W;
            sp_d    = ZERO_W;
            bad_d   = bad_q;
         end
      endcase
   end

   // Pipeline register and sticky reserved-code flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ir_q    <= BUBBLE_IR;
         valid_q <= 1'b0;
         data1_q <= ZERO_W;
         data2_q <= ZERO_W;
         sp_q    <= ZERO_W;
         bad_q   <= 1'b0;
      end else begin
         ir_q    <= ir_d;
         valid_q <= valid_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         sp_q    <= sp_d;
         bad_q   <= bad_d;
      end
   end

   assign exe_ir_o    = ir_q;
   assign exe_valid_o = valid_q;
   assign exe_data1_o = data1_q;
   assign exe_data2_o = data2_q;
   assign exe_sp_o    = sp_q;
   assign bad_code_o  = bad_q;

`ifdef BEXKAT1_BYPASS_PERF_EN
   logic [15:0] stall_cnt_d, stall_cnt_q;
   logic [15:0] fwd_cnt_d,   fwd_cnt_q;

   // Saturating performance counters: stall cycles, and valid instructions that use any forwarding path.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      fwd_cnt_d   = fwd_cnt_q;
      if ((mode_s == MODE_STALL) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if ((mode_s == MODE_ADVANCE) && (id_ir_i != BUBBLE_IR) && any_fwd_s &&
          (fwd_cnt_q != 16'hFFFF)) begin
         fwd_cnt_d = fwd_cnt_q + 16'd1;
      end else begin
         fwd_cnt_d = fwd_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= 16'h0;
         fwd_cnt_q   <= 16'h0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         fwd_cnt_q   <= fwd_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign fwd_cnt_o   = fwd_cnt_q;
`else
   logic unused_perf_s;
   assign unused_perf_s = any_fwd_s;
   assign stall_cnt_o   = 16'h0;
   assign fwd_cnt_o     = 16'h0;
`endif

endmodule

// File: tb/tb_operand_bypass.sv
// Testbench for operand_bypass.
//
// The driver applies directed vectors at the falling edge. For each vector it
// pushes the hand-computed response into a scoreboard queue. The monitor pops
// one entry after every rising edge and compares it with the DUT outputs.
// When BEXKAT1_BYPASS_PERF_EN is defined, the bench also checks that the
// counters saturate. When it is undefined, both counters must read zero.

module tb_operand_bypass;

   localparam logic [31:0] D1      = 32'h0000_AAAA;
   localparam logic [31:0] D2      = 32'h0000_BBBB;
   localparam logic [31:0] IDSP    = 32'h0000_CCCC;
   localparam logic [31:0] EXE_RES = 32'h0000_1111;
   localparam logic [31:0] MEM_RES = 32'h0000_2222;
   localparam logic [31:0] EXE_SP  = 32'h0000_FF00;
   localparam logic [31:0] MEM_SP  = 32'h0000_FE00;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i, flush_i;
   logic [2:0]  hazard1_i, hazard2_i;
   logic [1:0]  sp_hazard_i;
   logic [63:0] id_ir_i;
   logic [31:0] id_data1_i, id_data2_i, id_sp_i;
   logic [31:0] exe_result_i, exe_sp_i, mem_result_i, mem_sp_i;
   logic [63:0] exe_ir_o;
   logic        exe_valid_o;
   logic [31:0] exe_data1_o, exe_data2_o, exe_sp_o;
   logic        bad_code_o;
   logic [15:0] stall_cnt_o, fwd_cnt_o;

   typedef struct {
      string       name;
      logic [63:0] ir;
      logic        valid;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] sp;
      logic        bad;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] m_sc = 16'h0;
   logic [15:0] m_fc = 16'h0;

   operand_bypass #(.WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .hazard1_i(hazard1_i), .hazard2_i(hazard2_i), .sp_hazard_i(sp_hazard_i),
      .id_ir_i(id_ir_i), .id_data1_i(id_data1_i), .id_data2_i(id_data2_i),
      .id_sp_i(id_sp_i), .exe_result_i(exe_result_i), .exe_sp_i(exe_sp_i),
      .mem_result_i(mem_result_i), .mem_sp_i(mem_sp_i),
      .exe_ir_o(exe_ir_o), .exe_valid_o(exe_valid_o),
      .exe_data1_o(exe_data1_o), .exe_data2_o(exe_data2_o), .exe_sp_o(exe_sp_o),
      .bad_code_o(bad_code_o), .stall_cnt_o(stall_cnt_o), .fwd_cnt_o(fwd_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input string field,
                        input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s.%s: got %h, expected %h", name, field, act, req);
      end
   endtask

   task automatic check_all_zero(input string name);
      check(name, "ir",    exe_ir_o, 64'h0);
      check(name, "valid", {63'h0, exe_valid_o}, 64'h0);
      check(name, "d1",    {32'h0, exe_data1_o}, 64'h0);
      check(name, "d2",    {32'h0, exe_data2_o}, 64'h0);
      check(name, "sp",    {32'h0, exe_sp_o}, 64'h0);
      check(name, "bad",   {63'h0, bad_code_o}, 64'h0);
      check(name, "scnt",  {48'h0, stall_cnt_o}, 64'h0);
      check(name, "fcnt",  {48'h0, fwd_cnt_o}, 64'h0);
   endtask

   // Drive one vector at the falling edge and push its hand-computed response.
   task automatic drive(input string name, input logic fl, input logic st,
                        input logic [2:0] h1, input logic [2:0] h2, input logic [1:0] sph,
                        input logic [63:0] ir, input logic [31:0] e_d1,
                        input logic [31:0] e_d2, input logic [31:0] e_sp, input logic e_bad);
      exp_t e;
      @(negedge clk_i);
      flush_i = fl; stall_i = st; hazard1_i = h1; hazard2_i = h2;
      sp_hazard_i = sph; id_ir_i = ir;
      if (fl) begin
         m_sc = m_sc;
      end else if (st) begin
         if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      end else if ((ir != 64'h0) && ((h1 != 3'd0) || (h2 != 3'd0) || (sph != 2'd0))) begin
         if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      end
      e.name  = name;
      e.ir    = (fl || st) ? 64'h0 : ir;
      e.valid = (fl || st) ? 1'b0 : (ir != 64'h0);
      e.d1 = e_d1; e.d2 = e_d2; e.sp = e_sp; e.bad = e_bad;
`ifdef BEXKAT1_BYPASS_PERF_EN
      e.sc = m_sc; e.fc = m_fc;
`else
      e.sc = 16'h0; e.fc = 16'h0;
`endif
      sb_q.push_back(e);
   endtask

   // Assert reset between edges. The first edge after release is a flush, so it must give all zeros.
   task automatic mid_reset();
      exp_t e;
      @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1 check_all_zero("mid_reset_async");
      flush_i = 1'b1; stall_i = 1'b0;
      rst_i = 1'b1;
      m_sc = 16'h0; m_fc = 16'h0;
      e.name = "post_reset_flush"; e.ir = 64'h0; e.valid = 1'b0;
      e.d1 = 32'h0; e.d2 = 32'h0; e.sp = 32'h0; e.bad = 1'b0;
      e.sc = 16'h0; e.fc = 16'h0;
      sb_q.push_back(e);
   endtask

   // Monitor: after each rising edge, compare the DUT with the oldest expected response.
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, "ir",    exe_ir_o, mon_e.ir);
            check(mon_e.name, "valid", {63'h0, exe_valid_o}, {63'h0, mon_e.valid});
            check(mon_e.name, "d1",    {32'h0, exe_data1_o}, {32'h0, mon_e.d1});
            check(mon_e.name, "d2",    {32'h0, exe_data2_o}, {32'h0, mon_e.d2});
            check(mon_e.name, "sp",    {32'h0, exe_sp_o}, {32'h0, mon_e.sp});
            check(mon_e.name, "bad",   {63'h0, bad_code_o}, {63'h0, mon_e.bad});
            check(mon_e.name, "scnt",  {48'h0, stall_cnt_o}, {48'h0, mon_e.sc});
            check(mon_e.name, "fcnt",  {48'h0, fwd_cnt_o}, {48'h0, mon_e.fc});
         end
      end
   end

   // Watchdog: stop the run if the stimulus never completes.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus.
   initial begin
      rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      hazard1_i = 3'd0; hazard2_i = 3'd0; sp_hazard_i = 2'd0; id_ir_i = 64'h0;
      id_data1_i = D1; id_data2_i = D2; id_sp_i = IDSP;
      exe_result_i = EXE_RES; mem_result_i = MEM_RES;
      exe_sp_i = EXE_SP; mem_sp_i = MEM_SP;
      #1 check_all_zero("reset_no_clock");
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;

      //     name          fl    st    h1    h2    sp    ir                        d1       d2       sp      bad
      drive("fwd_exe_mem", 1'b0, 1'b0, 3'd2, 3'd1, 2'd0, 64'h2012_0000_0000_0000, EXE_RES, MEM_RES, IDSP,   1'b0);
      drive("fwd_sp",      1'b0, 1'b0, 3'd3, 3'd4, 2'd0, 64'h1,                   MEM_SP,  EXE_SP,  IDSP,   1'b0);
      drive("sp_exe",      1'b0, 1'b0, 3'd0, 3'd0, 2'd1, 64'h2,                   D1,      D2,      EXE_SP, 1'b0);
      drive("sp_mem",      1'b0, 1'b0, 3'd0, 3'd0, 2'd2, 64'h3,                   D1,      D2,      MEM_SP, 1'b0);
      drive("flush_stall", 1'b1, 1'b1, 3'd6, 3'd0, 2'd3, 64'h4,                   32'h0,   32'h0,   32'h0,  1'b0);
      drive("stall_rsv",   1'b0, 1'b1, 3'd6, 3'd0, 2'd3, 64'h4,                   32'h0,   32'h0,   32'h0,  1'b0);
      drive("adv_bubble",  1'b0, 1'b0, 3'd2, 3'd0, 2'd0, 64'h0,                   EXE_RES, D2,      IDSP,   1'b0);
      drive("rsv_h1",      1'b0, 1'b0, 3'd6, 3'd0, 2'd0, 64'h5,                   D1,      D2,      IDSP,   1'b1);
      drive("rsv_sp",      1'b0, 1'b0, 3'd0, 3'd0, 2'd3, 64'h6,                   D1,      D2,      IDSP,   1'b1);
      drive("flush_hold",  1'b1, 1'b0, 3'd0, 3'd0, 2'd0, 64'h7,                   32'h0,   32'h0,   32'h0,  1'b1);
      drive("rsv_h2",      1'b0, 1'b0, 3'd0, 3'd7, 2'd0, 64'h8,                   D1,      D2,      IDSP,   1'b1);
      mid_reset();
      drive("after_reset", 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 64'h9,                   D1,      D2,      IDSP,   1'b0);
      drive("stall_rsv2",  1'b0, 1'b1, 3'd0, 3'd5, 2'd0, 64'h9,                   32'h0,   32'h0,   32'h0,  1'b0);
      drive("sp_rsv2",     1'b0, 1'b0, 3'd0, 3'd0, 2'd3, 64'hA,                   D1,      D2,      IDSP,   1'b1);
      drive("mixed_fwd",   1'b0, 1'b0, 3'd4, 3'd3, 2'd1, 64'hB,                   EXE_SP,  MEM_SP,  EXE_SP, 1'b1);
`ifdef BEXKAT1_BYPASS_PERF_EN
      for (int i = 0; i < 65540; i++) begin
         drive("stall_sat", 1'b0, 1'b1, 3'd0, 3'd0, 2'd0, 64'hC, 32'h0, 32'h0, 32'h0, 1'b1);
      end
      drive("post_sat",    1'b0, 1'b0, 3'd1, 3'd0, 2'd0, 64'hD,                   MEM_RES, D2,      IDSP,   1'b1);
`endif
      @(posedge clk_i);
      #2;
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_bypass.md
OPERAND_BYPASS -- requirements
Module: operand_bypass

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and results.
REQ-002 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_i  input  1  reset, asynchronous, active-low.
REQ-004 Port: stall_i  input  1  ID-stage stall request from hazard unit.
REQ-005 Port: flush_i  input  1  branch/exception flush of the ID-to-EXE transfer.
REQ-006 Port: hazard1_i  input  3  operand-1 source select code.
REQ-007 Port: hazard2_i  input  3  operand-2 source select code.
REQ-008 Port: sp_hazard_i  input  2  stack-pointer source select code.
REQ-009 Port: id_ir_i  input  64  decoded ID instruction word; 64'h0 means bubble.
REQ-010 Port: id_data1_i, id_data2_i, id_sp_i  input  WIDTH each  register-file/SP read values.
REQ-011 Port: exe_result_i, exe_sp_i  input  WIDTH each  EXE-stage result and SP value.
REQ-012 Port: mem_result_i, mem_sp_i  input  WIDTH each  MEM-stage result and SP value.
REQ-013 Port: exe_ir_o  output  64  registered instruction entering EXE.
REQ-014 Port: exe_valid_o  output  1  exe_ir_o holds a non-bubble instruction.
REQ-015 Port: exe_data1_o, exe_data2_o, exe_sp_o  output  WIDTH each  registered resolved operands.
REQ-016 Port: bad_code_o  output  1  sticky flag: reserved select code received.
REQ-017 Port: stall_cnt_o, fwd_cnt_o  output  16 each  performance counters (see Configuration).

Function
REQ-018 Operand select, hazard1_i/hazard2_i: 0 register file, 1 mem_result_i, 2 exe_result_i, 3 mem_sp_i, 4 exe_sp_i, 5-7 register file value and bad_code_o set.
REQ-019 SP select, sp_hazard_i: 0 id_sp_i, 1 exe_sp_i, 2 mem_sp_i, 3 id_sp_i and bad_code_o set.
REQ-020 Latency: exactly one cycle; outputs after edge N reflect inputs sampled at edge N.
REQ-021 Per-edge priority: flush_i > stall_i > advance.
REQ-022 Flush cycle: exe_ir_o=64'h0, exe_valid_o=0, all exe_data/sp outputs=0; select codes ignored, bad_code_o not updated.
REQ-023 Stall cycle (no flush): bubble inserted, same values as flush; ID instruction is re-presented later and resolved afresh, no operand value retained.
REQ-024 Advance cycle: exe_ir_o=id_ir_i, exe_valid_o=(id_ir_i!=0), operands per REQ-018/019.
REQ-025 Advance with id_ir_i=0: outputs loaded as selected, exe_valid_o=0; reserved codes still set bad_code_o.
REQ-026 bad_code_o only sets on advance cycles; cleared only by reset.
REQ-027 Block is a pure pipeline register plus mux: no handshake back-pressure, no combinational path input-to-output.

Reset
REQ-028 rst_i low asynchronously forces exe_ir_o=0, exe_valid_o=0, all data/sp outputs=0, bad_code_o=0, both counters=0.
REQ-029 Reset deassertion mid-stream: first rising edge with rst_i high performs a normal per-REQ-021 update.

Configuration
REQ-030 Macro BEXKAT1_BYPASS_PERF_EN defined: stall_cnt_o increments on each stall cycle (stall_i=1, flush_i=0); fwd_cnt_o increments once per advance cycle with valid id_ir_i where any select code is nonzero; both 16-bit, saturate at 16'hFFFF.
REQ-031 Macro undefined: counter logic absent, stall_cnt_o and fwd_cnt_o tied to 16'h0; all other behaviour identical.

Verification
REQ-032 Reset: assert rst_i low between edges -> all outputs 0 immediately, no clock needed.
REQ-033 Forward: id_ir_i=64'h2012_0000_0000_0000, hazard1_i=2, hazard2_i=1, exe_result_i=32'h1111, mem_result_i=32'h2222 -> next edge exe_data1_o=32'h1111, exe_data2_o=32'h2222, exe_valid_o=1.
REQ-034 Priority: flush_i=1 and stall_i=1 same edge, with PERF_EN -> bubble outputs, stall_cnt_o unchanged; stall_i=1 alone -> bubble, stall_cnt_o +1.
REQ-035 SP: sp_hazard_i=1 then 2, exe_sp_i=32'hFF00, mem_sp_i=32'hFE00 -> exe_sp_o FF00 then FE00; sp_hazard_i=3 -> exe_sp_o=id_sp_i, bad_code_o=1 held through subsequent cycles until reset.
REQ-036 Saturation (PERF_EN): hold stall_i=1 for 65540 cycles -> stall_cnt_o=16'hFFFF, no wrap; without macro both counters read 0.
REQ-037 Reserved code: hazard1_i=6 on advance -> exe_data1_o=id_data1_i, bad_code_o=1; same code during stall -> bad_code_o stays 0.
